// File: rtl/aes_pkg.sv
// Shared AES-128 constants, state encoding and byte-level helpers for the
// iterative decryption core.
package aes_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ROUND = 1'b1
    } fsm_e;

    localparam logic [127:0] FIXED_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K10       = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777b_f26b6fc5_3001672b_fed7ab76,
        128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
        128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
        128'h04c723c3_1896059a_071280e2_eb27b275,
        128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
        128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
        128'hd0efaafb_434d3385_45f9027f_503c9fa8,
        128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
        128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
        128'h60814fdc_222a9088_46eeb814_de5e0bdb,
        128'he0323a0a_4906245c_c2d3ac62_9195e479,
        128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
        128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
        128'h703eb566_4803f60e_613557b9_86c11d9e,
        128'he1f89811_69d98e94_9b1e87e9_ce5528df,
        128'h8ca1890d_bfe64268_41992d0f_b054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad5_3036a538_bf40a39e_81f3d7fb,
        128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
        128'h547b9432_a6c2233d_ee4c950b_42fac34e,
        128'h082ea166_28d924b2_765ba249_6d8bd125,
        128'h72f8f664_86689816_d4a45ccc_5d65b692,
        128'h6c704850_fdedb9da_5e154657_a78d9d84,
        128'h90d8ab00_8cbcd30a_f7e45805_b8b34506,
        128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
        128'h3a911141_4f67dcea_97f2cfce_f0b4e673,
        128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
        128'h47f11a71_1d29c589_6fb7620e_aa18be1b,
        128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
        128'h1fdda833_8807c731_b1121059_2780ec5f,
        128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
        128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961,
        128'h172b047e_ba77d626_e1691463_55210c7d
    };

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gmul_09(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmul_0b(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul_0d(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmul_0e(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gmul_0e(a0) ^ gmul_0b(a1) ^ gmul_0d(a2) ^ gmul_09(a3),
                gmul_09(a0) ^ gmul_0e(a1) ^ gmul_0b(a2) ^ gmul_0d(a3),
                gmul_0d(a0) ^ gmul_09(a1) ^ gmul_0e(a2) ^ gmul_0b(a3),
                gmul_0b(a0) ^ gmul_0d(a1) ^ gmul_09(a2) ^ gmul_0e(a3)};
    endfunction

    // Undo one key-schedule step: recovers round key rnd-1 from round key rnd.
    function automatic logic [127:0] inv_key_step(input logic [127:0] key, input logic [3:0] rnd);
        logic [31:0] w0, w1, w2, w3, p0, p1, p2, p3, rot;
        {w0, w1, w2, w3} = key;
        p3  = w3 ^ w2;
        p2  = w2 ^ w1;
        p1  = w1 ^ w0;
        rot = {p3[23:0], p3[31:24]};
        p0  = w0 ^ {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                 ^ {rcon(rnd), 24'h0};
        return {p0, p1, p2, p3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] round_key_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    logic [127:0] keyed;
    logic [127:0] mixed;

    // Byte (row r, column c) sits at bits [8*(15-(r+4c)) +: 8]; rows rotate right.
    always_comb begin
        keyed = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                keyed[8*(15-(r+4*c)) +: 8] =
                    inv_sbox(state_i[8*(15-(r+4*((c+4-r)%4))) +: 8]) ^ round_key_i[8*(15-(r+4*c)) +: 8];
            end
        end
    end

    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[32*(3-c) +: 32] = inv_mix_column(keyed[32*(3-c) +: 32]);
        end
    end

    assign state_o = last_i ? keyed : mixed;

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryption, one inverse round per clock with round keys
// rolled backwards from K10. Define AES_DECRYPT_ABORT_EN to add the abort input.
module aes_decrypt_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef AES_DECRYPT_ABORT_EN
    input  logic         abort,
`endif
    input  logic [127:0] in,
    output logic [127:0] out,
    output logic         done_decr,
    output logic         busy
);

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [127:0] out_q, out_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         done_q, done_d;

    logic [127:0] prev_key;
    logic [127:0] round_out;
    logic         last_round;
    logic         abort_req;

`ifdef AES_DECRYPT_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign prev_key   = inv_key_step(key_q, rnd_q);
    assign last_round = (rnd_q == 4'd1);

    aes_inv_round u_inv_round (
        .state_i     (state_q),
        .round_key_i (prev_key),
        .last_i      (last_round),
        .state_o     (round_out)
    );

    // NOTE: every variable gets its hold value first so no path through the
    // case leaves it unassigned; that is what keeps this block latch-free.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        out_d   = out_q;
        done_d  = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                if (start) begin
                    state_d = in ^ K10;
                    key_d   = K10;
                    rnd_d   = 4'd10;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                if (abort_req) begin
                    fsm_d = IDLE;
                end else if (last_round) begin
                    out_d  = round_out;
                    done_d = 1'b1;
                    fsm_d  = IDLE;
                end else begin
                    state_d = round_out;
                    key_d   = prev_key;
                    rnd_d   = rnd_q - 4'd1;
                end
            end
        endcase
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge
    // values computed above, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            out_q   <= '0;
            rnd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            out_q   <= out_d;
            rnd_q   <= rnd_d;
            done_q  <= done_d;
        end
    end

    assign out       = out_q;
    assign done_decr = done_q;
    assign busy      = (fsm_q == ROUND);

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Self-checking bench for aes_decrypt_iter against an independent byte-array
// AES model whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_decrypt_iter;

    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] din;
    logic [127:0] dout;
    logic         done_decr;
    logic         busy;
`ifdef AES_DECRYPT_ABORT_EN
    logic         abort;
`endif

    aes_decrypt_iter dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef AES_DECRYPT_ABORT_EN
        .abort     (abort),
`endif
        .in        (din),
        .out       (dout),
        .done_decr (done_decr),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];
    logic [127:0] rk  [11];

    // done_decr must never be seen high on two consecutive cycles
    logic done_prev = 1'b0;
    int   double_cnt = 0;
    always @(negedge clk) begin
        if (done_decr && done_prev) double_cnt <= double_cnt + 1;
        done_prev <= done_decr;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    task automatic build_model();
        logic [7:0]  inv, b, s, rc;
        logic [31:0] w [44];
        logic [31:0] t;
        logic [127:0] key_v;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
            sb[x]  = s;
            isb[s] = 8'(x);
        end
        key_v = KEY;
        for (int i = 0; i < 4; i++) w[i] = key_v[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int ro = 0; ro < 4; ro++)
                    t[ro+4*c] = sb[s[ro+4*((c+ro)%4)]];
            for (int c = 0; c < 4; c++)
                for (int ro = 0; ro < 4; ro++)
                    if (r < 10)
                        s[ro+4*c] = gf_mul(8'h02, t[ro+4*c]) ^ gf_mul(8'h03, t[(ro+1)%4+4*c])
                                  ^ t[(ro+2)%4+4*c] ^ t[(ro+3)%4+4*c];
                    else
                        s[ro+4*c] = t[ro+4*c];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] model_decrypt(input logic [127:0] ct);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ rk[10][127-8*i -: 8];
        for (int r = 9; r >= 0; r--) begin
            for (int c = 0; c < 4; c++)
                for (int ro = 0; ro < 4; ro++)
                    t[ro+4*c] = isb[s[ro+4*((c+4-ro)%4)]] ^ rk[r][127-8*(ro+4*c) -: 8];
            for (int c = 0; c < 4; c++)
                for (int ro = 0; ro < 4; ro++)
                    if (r > 0)
                        s[ro+4*c] = gf_mul(8'h0e, t[ro+4*c]) ^ gf_mul(8'h0b, t[(ro+1)%4+4*c])
                                  ^ gf_mul(8'h0d, t[(ro+2)%4+4*c]) ^ gf_mul(8'h09, t[(ro+3)%4+4*c]);
                    else
                        s[ro+4*c] = t[ro+4*c];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Waits (bounded) for done_decr; lat counts clocks after the accepting edge.
    task automatic wait_done(output int lat, output logic busy_pre);
        lat      = 0;
        busy_pre = busy;
        while (!done_decr && lat < 40) begin
            busy_pre = busy;
            tick();
            lat++;
        end
    endtask

    task automatic run_block(input logic [127:0] ct, output int lat,
                             output logic busy_pre, output logic busy_at);
        din   = ct;
        start = 1'b1;
        tick();
        start = 1'b0;
        din   = rand128();
        wait_done(lat, busy_pre);
        busy_at = busy;
    endtask

    typedef struct {
        string        name;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t         vecs [4];
    int           exp_acc  [$];
    int           done_cyc [$];
    logic [127:0] done_out [$];
    logic [127:0] in_hist  [30];

    initial begin
        int           lat, n, a;
        logic         bp, ba;
        logic [127:0] pt, held;

        build_model();

        vecs[0].name = "fips_c1";
        vecs[0].ct   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        vecs[0].pt   = 128'h00112233445566778899aabbccddeeff;
        vecs[1].name = "zero_ct";
        vecs[1].ct   = '0;
        vecs[1].pt   = model_decrypt('0);
        vecs[2].name = "ones_pt";
        vecs[2].ct   = model_encrypt('1);
        vecs[2].pt   = '1;
        vecs[3].name = "key_pt";
        vecs[3].ct   = model_encrypt(KEY);
        vecs[3].pt   = KEY;

        rst   = 1'b1;
        start = 1'b0;
        din   = '0;
`ifdef AES_DECRYPT_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) tick();
        check("reset_out", dout, '0);
        check("reset_done", 128'(done_decr), 0);
        check("reset_busy", 128'(busy), 0);
        #2 rst = 1'b0;

        din = rand128();
        repeat (3) tick();
        check("idle_busy", 128'(busy), 0);
        check("idle_out", dout, '0);

        // Directed vectors: result, latency, busy/done alignment, pulse width.
        for (int v = 0; v < 4; v++) begin
            run_block(vecs[v].ct, lat, bp, ba);
            check({vecs[v].name, "_out"}, dout, vecs[v].pt);
            check({vecs[v].name, "_latency"}, 128'(lat), 128'(10));
            check({vecs[v].name, "_busy_before"}, 128'(bp), 1);
            check({vecs[v].name, "_busy_at_done"}, 128'(ba), 0);
            tick();
            check({vecs[v].name, "_done_pulse"}, 128'(done_decr), 0);
            check({vecs[v].name, "_out_hold"}, dout, vecs[v].pt);
        end

        // Round trip on random plaintexts.
        for (int k = 0; k < 200; k++) begin
            pt = rand128();
            run_block(model_encrypt(pt), lat, bp, ba);
            check("roundtrip", dout, pt);
        end

        // start held high with a changing input: accepts only when idle.
        a = 0;
        while (a < 30) begin
            exp_acc.push_back(a);
            a += 11;
        end
        for (int k = 0; k < 30; k++) begin
            in_hist[k] = rand128();
            din   = in_hist[k];
            start = 1'b1;
            tick();
            if (done_decr) begin
                done_cyc.push_back(k);
                done_out.push_back(dout);
            end
        end
        start = 1'b0;
        for (int k = 30; k < 60 && done_cyc.size() < exp_acc.size(); k++) begin
            tick();
            if (done_decr) begin
                done_cyc.push_back(k);
                done_out.push_back(dout);
            end
        end
        check("b2b_count", 128'(done_cyc.size()), 128'(exp_acc.size()));
        for (int j = 0; j < exp_acc.size() && j < done_cyc.size(); j++) begin
            check("b2b_done_cycle", 128'(done_cyc[j]), 128'(exp_acc[j] + 10));
            check("b2b_out", done_out[j], model_decrypt(in_hist[exp_acc[j]]));
        end

        // Reset in the middle of a block.
        din   = rand128();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_out", dout, '0);
        check("midrst_done", 128'(done_decr), 0);
        check("midrst_busy", 128'(busy), 0);
        repeat (2) tick();
        #2 rst = 1'b0;
        n = 0;
        repeat (15) begin
            tick();
            if (done_decr) n++;
        end
        check("midrst_no_done", 128'(n), 0);
        check("midrst_out_kept", dout, '0);
        pt = rand128();
        run_block(model_encrypt(pt), lat, bp, ba);
        check("after_rst_out", dout, pt);
        check("after_rst_latency", 128'(lat), 128'(10));

`ifdef AES_DECRYPT_ABORT_EN
        run_block(vecs[0].ct, lat, bp, ba);
        held = dout;
        check("abort_setup_out", held, vecs[0].pt);

        din   = rand128();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 128'(busy), 0);
        check("abort_done", 128'(done_decr), 0);
        n = 0;
        repeat (15) begin
            tick();
            if (done_decr) n++;
        end
        check("abort_no_done", 128'(n), 0);
        check("abort_out_kept", dout, held);

        din   = rand128();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("abort_last_busy_pre", 128'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_last_done", 128'(done_decr), 0);
        check("abort_last_busy", 128'(busy), 0);
        check("abort_last_out", dout, held);

        pt    = rand128();
        din   = model_encrypt(pt);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        wait_done(lat, bp);
        check("abort_idle_out", dout, pt);
        check("abort_idle_latency", 128'(lat), 128'(10));
`endif

        tick();
        check("done_never_double", 128'(double_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
